// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: a DIGIT-bit ripple chain reused over WIDTH/DIGIT cycles,
// with start/busy/done handshake and carry/overflow flags.
module serial_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  generate
    if (DIGIT == 0 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $fatal(1, "serial_adder: DIGIT must be nonzero and divide WIDTH, WIDTH must be >= 2");
    end
  endgenerate

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic                   load, step, last;
  logic [WIDTH-1:0]       opa, opb, acc, acc_nxt;
  logic                   carry;
  logic [CW-1:0]          count;
  logic [DIGIT:0]         chain_c;
  logic [DIGIT-1:0]       dsum;
  logic [WIDTH+DIGIT-1:0] acc_cat;

  assign last = (count == CW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: load = start;
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
      end
      default: ;
    endcase
  end

  // DIGIT-bit ripple chain over the low digit of the operand shifters
  always_comb begin
    chain_c    = '0;
    dsum       = '0;
    chain_c[0] = carry;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dsum[i]      = opa[i] ^ opb[i] ^ chain_c[i];
      chain_c[i+1] = (opa[i] & opb[i]) | (chain_c[i] & (opa[i] ^ opb[i]));
    end
  end

  // Result digits enter at the MSB so the final digit lands the word in place
  assign acc_cat = {dsum, acc};
  assign acc_nxt = acc_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      count     <= '0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        opa   <= a;
        opb   <= sub ? ~b : b;
        carry <= sub;
        count <= '0;
      end else if (step) begin
        opa   <= opa >> DIGIT;
        opb   <= opb >> DIGIT;
        acc   <= acc_nxt;
        carry <= chain_c[DIGIT];
        count <= count + CW'(1);
        if (last) begin
          sum       <= acc_nxt;
          carry_out <= chain_c[DIGIT];
          overflow  <= chain_c[DIGIT] ^ chain_c[DIGIT-1];
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: four configurations run against an arithmetic
// reference model, plus directed literal checks of results, latency and handshake.
module tb_serial_adder;

  logic        clk;
  logic        rst;
  logic        st[4];
  logic        sb[4];
  logic [31:0] av[4];
  logic [31:0] bv[4];

  logic        dbusy[4];
  logic        ddone[4];
  logic        dc[4];
  logic        dv[4];
  logic [31:0] dsum[4];

  logic [3:0]  s4;
  logic [7:0]  s8, s88;
  logic [31:0] s32;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(4), .DIGIT(1)) u4 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .a(av[0][3:0]), .b(bv[0][3:0]),
    .busy(dbusy[0]), .done(ddone[0]), .sum(s4), .carry_out(dc[0]), .overflow(dv[0]));

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
    .busy(dbusy[1]), .done(ddone[1]), .sum(s8), .carry_out(dc[1]), .overflow(dv[1]));

  serial_adder #(.WIDTH(32), .DIGIT(4)) u32 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .a(av[2]), .b(bv[2]),
    .busy(dbusy[2]), .done(ddone[2]), .sum(s32), .carry_out(dc[2]), .overflow(dv[2]));

  serial_adder #(.WIDTH(8), .DIGIT(8)) u88 (
    .clk(clk), .rst(rst), .start(st[3]), .sub(sb[3]), .a(av[3][7:0]), .b(bv[3][7:0]),
    .busy(dbusy[3]), .done(ddone[3]), .sum(s88), .carry_out(dc[3]), .overflow(dv[3]));

  assign dsum[0] = {28'd0, s4};
  assign dsum[1] = {24'd0, s8};
  assign dsum[2] = s32;
  assign dsum[3] = {24'd0, s88};

  function automatic int wof(int k);
    case (k)
      0: return 4;
      2: return 32;
      default: return 8;
    endcase
  endfunction

  function automatic int nof(int k);
    case (k)
      0: return 4;
      1: return 8;
      2: return 8;
      default: return 1;
    endcase
  endfunction

  // Reference arithmetic: returns {overflow, carry_out, sum}
  function automatic logic [33:0] calc(int w, logic [31:0] x, logic [31:0] y, logic s);
    logic [63:0] mask, xa, yb, full;
    logic        sa, sgb, ss;
    mask = (64'd1 << w) - 64'd1;
    xa   = {32'd0, x} & mask;
    yb   = s ? (~{32'd0, y} & mask) : ({32'd0, y} & mask);
    full = xa + yb + {63'd0, s};
    sa   = xa[w-1];
    sgb  = yb[w-1];
    ss   = full[w-1];
    return {(sa == sgb) && (ss != sa), full[w], full[31:0] & mask[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: countdown to completion, result computed at acceptance
  int          rem[4];
  logic [33:0] pend[4];
  logic [31:0] msum[4];
  logic        mc[4], mv[4], mdone[4], mbusy[4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        rem[k] = 0; mbusy[k] = 1'b0; mdone[k] = 1'b0;
        msum[k] = '0; mc[k] = 1'b0; mv[k] = 1'b0;
      end else if (rem[k] == 0) begin
        mdone[k] = 1'b0;
        if (st[k]) begin
          pend[k]  = calc(wof(k), av[k], bv[k], sb[k]);
          rem[k]   = nof(k);
          mbusy[k] = 1'b1;
        end
      end else begin
        rem[k]--;
        if (rem[k] == 0) begin
          mdone[k] = 1'b1;
          mbusy[k] = 1'b0;
          {mv[k], mc[k], msum[k]} = pend[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("busy%0d", k), 64'(dbusy[k]), 64'(mbusy[k]));
        chk($sformatf("done%0d", k), 64'(ddone[k]), 64'(mdone[k]));
        chk($sformatf("sum%0d", k),  64'(dsum[k]),  64'(msum[k]));
        chk($sformatf("carry%0d", k), 64'(dc[k]),   64'(mc[k]));
        chk($sformatf("ovf%0d", k),  64'(dv[k]),    64'(mv[k]));
      end
    end
  end

  // One operation with literal expectations for latency and results
  task automatic measure(input int k, input logic [31:0] x, input logic [31:0] y, input logic s,
                         input int exp_lat, input logic [31:0] exp_sum, input logic exp_c,
                         input logic exp_v, input string nm);
    int lat;
    av[k] = x; bv[k] = y; sb[k] = s; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    lat = 0;
    while (!ddone[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_sum"}, 64'(dsum[k]), 64'(exp_sum));
    chk({nm, "_c"},   64'(dc[k]), 64'(exp_c));
    chk({nm, "_v"},   64'(dv[k]), 64'(exp_v));
  endtask

  initial begin
    int lat, ndone;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      st[k] = 1'b0; sb[k] = 1'b0; av[k] = '0; bv[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst    = 1'b0;

    // Pin the model against hand-computed values
    chk("model_7f01", 64'(calc(8, 32'h7F, 32'h01, 1'b0)), 64'({1'b1, 1'b0, 32'h80}));
    chk("model_0305", 64'(calc(8, 32'h03, 32'h05, 1'b1)), 64'({1'b0, 1'b0, 32'hFE}));
    chk("model_8001", 64'(calc(8, 32'h80, 32'h01, 1'b1)), 64'({1'b1, 1'b1, 32'h7F}));

    // Exhaustive 4-bit add sweep, back-to-back
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        av[0] = 32'(x); bv[0] = 32'(y); sb[0] = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (4) @(negedge clk);
      end
    end
    measure(0, 32'h9, 32'h8, 1'b0, 4, 32'h1, 1'b1, 1'b1, "w4_9p8");

    // 8-bit add/sub corner cases
    measure(1, 32'h7F, 32'h01, 1'b0, 8, 32'h80, 1'b0, 1'b1, "add_7f_01");
    measure(1, 32'hFF, 32'h01, 1'b0, 8, 32'h00, 1'b1, 1'b0, "add_ff_01");
    measure(1, 32'h80, 32'h80, 1'b0, 8, 32'h00, 1'b1, 1'b1, "add_80_80");
    measure(1, 32'h05, 32'h03, 1'b1, 8, 32'h02, 1'b1, 1'b0, "sub_05_03");
    measure(1, 32'h03, 32'h05, 1'b1, 8, 32'hFE, 1'b0, 1'b0, "sub_03_05");
    measure(1, 32'h80, 32'h01, 1'b1, 8, 32'h7F, 1'b1, 1'b1, "sub_80_01");

    // 32-bit, 4-bit digits: start pulsed again while busy must be ignored
    av[2] = 32'hFFFF_FFFF; bv[2] = 32'h1; sb[2] = 1'b0; st[2] = 1'b1;
    @(negedge clk);
    st[2] = 1'b0;
    lat = -1; ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (ddone[2]) begin
        ndone++;
        lat = c;
      end
      if (c == 1) begin
        st[2] = 1'b1; av[2] = 32'h1234; bv[2] = 32'h5;
      end
      if (c == 2) st[2] = 1'b0;
      @(negedge clk);
    end
    chk("w32_lat",   64'(lat), 64'd8);
    chk("w32_ndone", 64'(ndone), 64'd1);
    chk("w32_sum",   64'(dsum[2]), 64'd0);
    chk("w32_c",     64'(dc[2]), 64'd1);

    // Reset in the middle of an 8-bit operation
    av[1] = 32'h11; bv[1] = 32'h22; sb[1] = 1'b0; st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_sum",  64'(dsum[1]), 64'd0);
    chk("rst_c",    64'(dc[1]), 64'd0);
    chk("rst_v",    64'(dv[1]), 64'd0);
    chk("rst_busy", 64'(dbusy[1]), 64'd0);
    chk("rst_done", 64'(ddone[1]), 64'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ddone[1]) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'd0);
    measure(1, 32'h11, 32'h22, 1'b0, 8, 32'h33, 1'b0, 1'b0, "post_rst");

    // Full-width digit: one RUN cycle, start held high gives done every other cycle
    measure(3, 32'h12, 32'h34, 1'b0, 1, 32'h46, 1'b0, 1'b0, "w8d8");
    av[3] = 32'h12; bv[3] = 32'h34; sb[3] = 1'b0; st[3] = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ddone[3]) ndone++;
    end
    st[3] = 1'b0;
    chk("held_ndone", 64'(ndone), 64'd5);
    repeat (3) @(negedge clk);

    // Randomized traffic on all configurations, with rare resets
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++) begin
        st[k] = ($urandom_range(0, 2) == 0);
        sb[k] = 1'($urandom_range(0, 1));
        av[k] = $urandom;
        bv[k] = $urandom;
      end
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) st[k] = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
